gshare_predictor: RTL

- Parametrised successor to the single-table BHT: a direction predictor built from a table of saturating counters with a configurable depth and counter width.
- MODE selects the index function: bimodal (PC bits only) or gshare (PC XOR global history).
- Sits in place of the bht under top. Predicts on one port and trains on a separate resolve port.
- Owns a speculative global history register, repairs that register on a misprediction, and runs a self-initialisation sweep after reset.

---
 rtl/gshare_pkg.sv | 36 +++
 rtl/gshare_predictor_sat_counter_table.sv | 49 ++++
 rtl/gshare_predictor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/gshare_pkg.sv
// gshare_pkg: shared definitions for the gshare/bimodal direction predictor.
//   MODE_BIMODAL / MODE_GSHARE : index-function selectors for the MODE parameter
//   state_e                    : init-sweep / run state of the predictor
//   weak_nt()                  : weakly-not-taken counter value for a given width
//   sat_update()               : saturating increment/decrement of a counter
package gshare_pkg;

    localparam int unsigned MODE_BIMODAL = 0;
    localparam int unsigned MODE_GSHARE  = 1;

    // Widest counter the helpers handle; narrower counters are zero-extended.
    localparam int unsigned CTR_MAX_W = 4;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    function automatic logic [CTR_MAX_W-1:0] weak_nt(input int unsigned ctr_w);
        return CTR_MAX_W'((1 << (ctr_w - 1)) - 1);
    endfunction

    function automatic logic [CTR_MAX_W-1:0] sat_update(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 taken,
        input int unsigned          ctr_w = 2
    );
        logic [CTR_MAX_W-1:0] ctr_max;
        ctr_max = CTR_MAX_W'((1 << ctr_w) - 1);
        if (taken) begin
            return (ctr >= ctr_max) ? ctr : ctr + CTR_MAX_W'(1);
        end
        return (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter_table.sv
// sat_counter_table: flop array of saturating counters.
//   clk                    : clock (array is not reset; contents come from the init port)
//   rd_idx / rd_ctr        : asynchronous read port used by the predict path
//   init_en / init_idx     : writes the weakly-not-taken value to one entry
//   upd_en / upd_idx /
//   upd_taken              : saturating increment (taken) or decrement of one entry
// The init port has priority; the predictor never enables both at once.
module sat_counter_table
    import gshare_pkg::*;
#(
    parameter int unsigned TABLE_BITS = 10,
    parameter int unsigned CTR_W      = 2
) (
    input  logic                  clk,
    input  logic [TABLE_BITS-1:0] rd_idx,
    output logic [CTR_W-1:0]      rd_ctr,
    input  logic                  init_en,
    input  logic [TABLE_BITS-1:0] init_idx,
    input  logic                  upd_en,
    input  logic [TABLE_BITS-1:0] upd_idx,
    input  logic                  upd_taken
);

    localparam int unsigned    DEPTH   = 1 << TABLE_BITS;
    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(weak_nt(CTR_W));

    logic [CTR_W-1:0]     ctr_mem [DEPTH];
    logic [CTR_MAX_W-1:0] upd_cur;
    logic [CTR_MAX_W-1:0] upd_next;
    logic [CTR_W-1:0]     upd_wr;

    assign rd_ctr = ctr_mem[rd_idx];

    always_comb begin
        upd_cur               = '0;
        upd_cur[CTR_W-1:0]    = ctr_mem[upd_idx];
        upd_next              = sat_update(upd_cur, upd_taken, CTR_W);
        upd_wr                = CTR_W'(upd_next);
    end

    always_ff @(posedge clk) begin
        if (init_en) begin
            ctr_mem[init_idx] <= WEAK_NT;
        end else if (upd_en) begin
            ctr_mem[upd_idx] <= upd_wr;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: saturating-counter direction predictor, bimodal or gshare indexed.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   ready_o             : counter table initialised, requests accepted
//   pred_valid_i, pc_i  : prediction request
//   prediction_o,
//   pred_valid_o,
//   pred_hist_o         : one-cycle-latency prediction and the history it used
//   upd_valid_i,
//   upd_pc_i, upd_hist_i,
//   upd_taken_i,
//   upd_pred_i          : resolved branch; trains the counter and repairs history
// After reset the table is swept to weakly-not-taken, one entry per cycle.
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned TABLE_BITS = 10,
    parameter int unsigned CTR_W      = 2,
    parameter int unsigned HIST_W     = 10,
    parameter int unsigned MODE       = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              ready_o,
    input  logic              pred_valid_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              prediction_o,
    output logic              pred_valid_o,
    output logic [HIST_W-1:0] pred_hist_o,
    input  logic              upd_valid_i,
    input  logic [PC_W-1:0]   upd_pc_i,
    input  logic [HIST_W-1:0] upd_hist_i,
    input  logic              upd_taken_i,
    input  logic              upd_pred_i
);

    state_e                state, state_next;
    logic [TABLE_BITS-1:0] init_idx, init_idx_next;
    logic                  init_en;
    logic [HIST_W-1:0]     ghr, ghr_next;

    logic                  pred_fire, upd_fire, repair;
    logic [TABLE_BITS-1:0] pred_hist_ext, upd_hist_ext;
    logic [TABLE_BITS-1:0] pred_idx, upd_idx;
    logic [CTR_W-1:0]      pred_ctr;
    logic                  pred_bit;
    // One bit wider than the history so the shift works for HIST_W = 1 too.
    logic [HIST_W:0]       spec_cat, repair_cat;

    assign pred_fire = ready_o & pred_valid_i;
    assign upd_fire  = ready_o & upd_valid_i;
    assign repair    = upd_fire & (upd_taken_i != upd_pred_i);
    assign pred_bit  = pred_ctr[CTR_W-1];

    always_comb begin
        pred_hist_ext = '0;
        upd_hist_ext  = '0;
        if (MODE == MODE_GSHARE) begin
            pred_hist_ext[HIST_W-1:0] = ghr;
            upd_hist_ext[HIST_W-1:0]  = upd_hist_i;
        end
        pred_idx = pc_i[TABLE_BITS+1:2] ^ pred_hist_ext;
        upd_idx  = upd_pc_i[TABLE_BITS+1:2] ^ upd_hist_ext;
    end

    always_comb begin
        state_next    = state;
        init_idx_next = init_idx;
        init_en       = 1'b0;
        case (state)
            INIT: begin
                init_en       = 1'b1;
                init_idx_next = init_idx + TABLE_BITS'(1);
                if (init_idx == '1) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // A repair overrides the speculative shift of a same-cycle prediction.
    always_comb begin
        spec_cat   = {ghr, pred_bit};
        repair_cat = {upd_hist_i, upd_taken_i};
        ghr_next   = ghr;
        if (repair) begin
            ghr_next = repair_cat[HIST_W-1:0];
        end else if (pred_fire) begin
            ghr_next = spec_cat[HIST_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= INIT;
            init_idx     <= '0;
            ghr          <= '0;
            ready_o      <= 1'b0;
            pred_valid_o <= 1'b0;
            prediction_o <= 1'b0;
            pred_hist_o  <= '0;
        end else begin
            state        <= state_next;
            init_idx     <= init_idx_next;
            ghr          <= ghr_next;
            // Registered from state, so ready rises one edge after RUN is entered.
            ready_o      <= (state == RUN);
            pred_valid_o <= pred_fire;
            if (pred_fire) begin
                prediction_o <= pred_bit;
                pred_hist_o  <= ghr;
            end
        end
    end

    sat_counter_table #(
        .TABLE_BITS (TABLE_BITS),
        .CTR_W      (CTR_W)
    ) u_table (
        .clk       (clk_i),
        .rd_idx    (pred_idx),
        .rd_ctr    (pred_ctr),
        .init_en   (init_en),
        .init_idx  (init_idx),
        .upd_en    (upd_fire),
        .upd_idx   (upd_idx),
        .upd_taken (upd_taken_i)
    );

    // Bits outside the index window and the spare concatenation bits are intentionally unused.
    logic unused_ok;
    assign unused_ok = ^{pc_i, upd_pc_i, pred_ctr, spec_cat, repair_cat, upd_hist_i};

endmodule
